// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder result packer.
// Optional flush-to-zero of denormals is enabled with FP_PACK_FTZ_EN.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 24;
  localparam int EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_DONE
  } pack_state_e;

  localparam int FLG_OVF  = 2;
  localparam int FLG_UNF  = 1;
  localparam int FLG_ZERO = 0;

endpackage

// File: rtl/fp_norm_step.sv
// One renormalization step: first matching rule wins.
// FP_PACK_FTZ_EN turns denormal results into signed zero.
module fp_norm_step
  import fp_pkg::*;
(
  input  logic             sign_i,
  input  logic [EXP_W:0]   exp_i,
  input  logic             carry_i,
  input  logic [MAN_W-1:0] mant_i,
  output logic             sign_o,
  output logic [EXP_W:0]   exp_o,
  output logic             carry_o,
  output logic [MAN_W-1:0] mant_o,
  output logic             done_o,
  output logic [2:0]       flags_o
);

  localparam logic [EXP_W:0] EXP_TOP = {1'b0, EXP_INF};
  localparam logic [EXP_W:0] EXP_ONE = 9'd1;

  always_comb begin
    sign_o  = sign_i;
    exp_o   = exp_i;
    carry_o = carry_i;
    mant_o  = mant_i;
    done_o  = 1'b0;
    flags_o = 3'b000;
    priority case (1'b1)
      (exp_i >= EXP_TOP): begin
        exp_o            = EXP_TOP;
        mant_o           = '0;
        carry_o          = 1'b0;
        done_o           = 1'b1;
        flags_o[FLG_OVF] = 1'b1;
      end
      carry_i: begin
        mant_o  = {1'b1, mant_i[MAN_W-1:1]};
        exp_o   = exp_i + EXP_ONE;
        carry_o = 1'b0;
      end
      (mant_i == '0): begin
        sign_o            = 1'b0;
        exp_o             = '0;
        done_o            = 1'b1;
        flags_o[FLG_ZERO] = 1'b1;
      end
      mant_i[MAN_W-1]: begin
        done_o = 1'b1;
      end
      (exp_i == EXP_ONE): begin
        // Exponent field 0 marks the denormal; the frac keeps the mantissa.
        exp_o            = '0;
        done_o           = 1'b1;
        flags_o[FLG_UNF] = 1'b1;
`ifdef FP_PACK_FTZ_EN
        mant_o            = '0;
        flags_o[FLG_ZERO] = 1'b1;
`endif
      end
      default: begin
        mant_o = {mant_i[MAN_W-2:0], 1'b0};
        exp_o  = exp_i - EXP_ONE;
      end
    endcase
  end

endmodule

// File: rtl/fp_result_packer.sv
// Iterative normalizer/packer for the FP adder output (IEEE single).
// FP_PACK_FTZ_EN selects flush-to-zero for denormal results.
module fp_result_packer
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_carry,
  input  logic [MAN_W-1:0] in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [2:0]       out_flags
);

  pack_state_e      state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic             carry_q, carry_d;
  logic [MAN_W-1:0] mant_q, mant_d;
  logic             vld_q, vld_d;
  logic [31:0]      word_q, word_d;
  logic [2:0]       flags_q, flags_d;

  logic             st_sign;
  logic [EXP_W:0]   st_exp;
  logic             st_carry;
  logic [MAN_W-1:0] st_mant;
  logic             st_done;
  logic [2:0]       st_flags;

  fp_norm_step u_step (
    .sign_i  (sign_q),
    .exp_i   (exp_q),
    .carry_i (carry_q),
    .mant_i  (mant_q),
    .sign_o  (st_sign),
    .exp_o   (st_exp),
    .carry_o (st_carry),
    .mant_o  (st_mant),
    .done_o  (st_done),
    .flags_o (st_flags)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    carry_d = carry_q;
    mant_d  = mant_q;
    vld_d   = vld_q;
    word_d  = word_q;
    flags_d = flags_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          // A zero biased exponent is treated as the denormal scale 1.
          exp_d   = (in_exp == '0) ? 9'd1 : {1'b0, in_exp};
          carry_d = in_carry;
          mant_d  = in_mant;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        sign_d  = st_sign;
        exp_d   = st_exp;
        carry_d = st_carry;
        mant_d  = st_mant;
        if (st_done) begin
          vld_d   = 1'b1;
          word_d  = {st_sign, st_exp[EXP_W-1:0], st_mant[MAN_W-2:0]};
          flags_d = st_flags;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      carry_q <= 1'b0;
      mant_q  <= '0;
      vld_q   <= 1'b0;
      word_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      carry_q <= carry_d;
      mant_q  <= mant_d;
      vld_q   <= vld_d;
      word_q  <= word_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = vld_q;
  assign out_word  = word_q;
  assign out_flags = flags_q;

endmodule
